// File: rtl/sort_pkg.sv
// sort_pkg: shared types for the bitonic sort pipeline (element, vector, control state).
package sort_pkg;
  localparam int unsigned sort_width = 8;
  localparam int unsigned sort_index = 8;
  localparam int unsigned sort_index_width = 3;
  typedef logic [sort_width-1:0] elem_t;
  typedef elem_t vec_t [0:sort_index-1];
  typedef enum logic {IDLE, DRAIN} state_t;
endpackage

// File: rtl/sort_vec_buf.sv
// sort_vec_buf: one-vector holding register (data + desc flag + valid) with load/clear; ports clk, rst (async active-low), load, clear, d_data, d_desc -> data, desc, valid.
module sort_vec_buf
  import sort_pkg::*;
#(
  parameter int width = sort_width,
  parameter int index = sort_index
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [width-1:0] d_data [index],
  input  logic             d_desc,
  output logic [width-1:0] data [index],
  output logic             desc,
  output logic             valid
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data  <= '{default: '0};
      desc  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= d_data;
      desc  <= d_desc;
      valid <= 1'b1;
    end else if (clear) valid <= 1'b0;
endmodule

// File: rtl/sort_unloader.sv
// sort_unloader: serialises sorted vectors (vec_valid/vec_ready/vec_data/vec_desc) into one-element beats (out_valid/out_ready/out_data/out_idx/out_last) with a one-vector pending buffer; clk, rst async active-low.
module sort_unloader
  import sort_pkg::*;
#(
  parameter int width       = sort_width,
  parameter int index       = sort_index,
  parameter int index_width = sort_index_width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vec_valid,
  output logic                   vec_ready,
  input  logic [width-1:0]       vec_data [index],
  input  logic                   vec_desc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [width-1:0]       out_data,
  output logic [index_width-1:0] out_idx,
  output logic                   out_last
);
  localparam logic [index_width-1:0] last_cnt = index_width'(index - 1);
  state_t state, state_nx;
  logic [index_width-1:0] cnt, cnt_nx;
  logic [width-1:0] act_data [index];
  logic [width-1:0] pend_data [index];
  logic [width-1:0] load_data [index];
  logic act_desc, act_valid, pend_desc, pend_valid, load_desc;
  logic vec_hs, beat_hs, last_hs, act_load, act_clear, pend_load, pend_clear;
  assign vec_ready = !pend_valid;
  assign out_valid = (state == DRAIN) && act_valid;
  assign vec_hs    = vec_valid && vec_ready;
  assign beat_hs   = out_valid && out_ready;
  assign last_hs   = beat_hs && (cnt == last_cnt);
  // The active buffer reloads from idle, or on the last beat from pending (preferred) or straight from the input.
  assign act_load   = (vec_hs && state == IDLE) || (last_hs && (pend_valid || vec_hs));
  assign act_clear  = last_hs && !act_load;
  assign pend_load  = vec_hs && state == DRAIN && !last_hs;
  assign pend_clear = last_hs && pend_valid;
  assign out_data   = act_data[act_desc ? last_cnt - cnt : cnt];
  assign out_idx    = cnt;
  assign out_last   = out_valid && (cnt == last_cnt);
  always_comb begin
    load_data = vec_data;
    load_desc = vec_desc;
    if (pend_valid) begin
      load_data = pend_data;
      load_desc = pend_desc;
    end
  end
  always_comb begin
    state_nx = act_load ? DRAIN : last_hs ? IDLE : state;
    cnt_nx   = (act_load || last_hs) ? '0 : beat_hs ? cnt + index_width'(1) : cnt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  sort_vec_buf #(.width(width), .index(index)) u_act (
    .clk(clk), .rst(rst), .load(act_load), .clear(act_clear),
    .d_data(load_data), .d_desc(load_desc),
    .data(act_data), .desc(act_desc), .valid(act_valid)
  );
  sort_vec_buf #(.width(width), .index(index)) u_pend (
    .clk(clk), .rst(rst), .load(pend_load), .clear(pend_clear),
    .d_data(vec_data), .d_desc(vec_desc),
    .data(pend_data), .desc(pend_desc), .valid(pend_valid)
  );
endmodule

// File: tb/tb_sort_unloader.sv
// tb_sort_unloader: directed self-checking bench for sort_unloader.
module tb_sort_unloader;
  import sort_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vec_valid = 1'b0;
  logic vec_ready;
  vec_t vec_data = '{default: '0};
  logic vec_desc = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  elem_t out_data;
  logic [2:0] out_idx;
  logic out_last;
  int tests = 0;
  int fails = 0;
  vec_t va = '{8'd3, 8'd9, 8'd12, 8'd20, 8'd41, 8'd77, 8'd200, 8'd255};
  vec_t vb = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  vec_t vc = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
  logic [3:0] ready_pat = 4'b1001;

  sort_unloader dut (
    .clk(clk), .rst(rst), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .vec_desc(vec_desc), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input elem_t d, input int k);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"}, 32'(out_data), 32'(d));
    chk({tag, " idx"}, 32'(out_idx), 32'(k));
    chk({tag, " last"}, 32'(out_last), 32'(k == 7));
  endtask

  task automatic offer(input vec_t v, input logic desc);
    @(negedge clk);
    vec_valid = 1'b1;
    vec_data  = v;
    vec_desc  = desc;
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst vec_ready", 32'(vec_ready), 1);
    chk("rst out_idx", 32'(out_idx), 0);
    chk("rst out_last", 32'(out_last), 0);
    chk("rst out_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b1;
    // ascending single vector
    offer(va, 1'b0);
    for (int k = 0; k < 8; k++) begin
      beat("asc", va[k], k);
      @(negedge clk);
    end
    chk("asc idle valid", 32'(out_valid), 0);
    chk("asc idle ready", 32'(vec_ready), 1);
    // descending single vector
    offer(va, 1'b1);
    for (int k = 0; k < 8; k++) begin
      beat("desc", va[7-k], k);
      @(negedge clk);
    end
    chk("desc idle valid", 32'(out_valid), 0);
    // back-to-back via pending; a third vector is refused while pending is full
    offer(va, 1'b0);
    for (int k = 0; k < 16; k++) begin
      beat("b2b", k < 8 ? va[k] : vb[k-8], k % 8);
      chk("b2b vec_ready", 32'(vec_ready), 32'(k <= 2 || k >= 8));
      vec_valid = (k == 2) || (k >= 4 && k <= 7);
      vec_data  = (k == 2) ? vb : vc;
      vec_desc  = 1'b0;
      @(negedge clk);
    end
    vec_valid = 1'b0;
    chk("b2b idle valid", 32'(out_valid), 0);
    chk("b2b idle ready", 32'(vec_ready), 1);
    // backpressure pattern 1,0,0,1
    offer(va, 1'b0);
    begin
      int e = 0;
      for (int c = 0; c < 40 && e < 8; c++) begin
        out_ready = ready_pat[3 - (c % 4)];
        beat("stall", va[e], e);
        if (out_ready) e++;
        @(negedge clk);
      end
      chk("stall count", 32'(e), 8);
    end
    out_ready = 1'b1;
    chk("stall idle valid", 32'(out_valid), 0);
    // asynchronous reset mid-drain with pending full
    offer(va, 1'b0);
    for (int k = 0; k < 4; k++) begin
      beat("pre rst", va[k], k);
      vec_valid = (k == 2);
      vec_data  = vb;
      @(negedge clk);
    end
    vec_valid = 1'b0;
    beat("pre rst", va[4], 4);
    chk("pre rst pend", 32'(vec_ready), 0);
    #2 rst = 1'b0;
    #1;
    chk("arst out_valid", 32'(out_valid), 0);
    chk("arst vec_ready", 32'(vec_ready), 1);
    chk("arst out_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post rst valid", 32'(out_valid), 0);
      chk("post rst idx", 32'(out_idx), 0);
    end
    offer(vb, 1'b1);
    for (int k = 0; k < 8; k++) begin
      beat("fresh", vb[7-k], k);
      @(negedge clk);
    end
    chk("fresh idle valid", 32'(out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
